nf_channel_filter: RTL

NF_CHANNEL_FILTER -- requirements
Module: nf_channel_filter

---
 rtl/crpa_pkg.sv | 17 +
 rtl/nf_sat_round.sv | 38 +++
 rtl/nf_channel_filter.sv | 83 ++++++++
 3 files changed

// File: rtl/crpa_pkg.sv
// crpa_pkg: shared default widths and width helpers for the channel filter
package crpa_pkg;
  localparam int NCH_D = 4;
  localparam int NT_D = 8;
  localparam int WIDTH_D = 14;
  localparam int CFWIDTH_D = 16;
  localparam int NORM_WIDTH_D = 16;
  localparam int OUT_WIDTH_D = 14;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction
  function automatic int acc_w(input int width, input int cfwidth, input int n);
    return width + cfwidth + clog2(n);
  endfunction
endpackage

// File: rtl/nf_sat_round.sv
// nf_sat_round: half-up rounding right shift, output saturation and sticky clip flag
module nf_sat_round #(
  parameter int IW = 51,
  parameter int OW = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic signed [IW-1:0] in_data,
  input  logic [4:0]           shift,
  input  logic                 sat_clr,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  output logic                 sat_flag
);
  localparam int RW = IW + 1;
  localparam logic signed [RW-1:0] HI = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] LO = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic signed [RW-1:0] rnd, sh;
  logic signed [OW-1:0] y;
  logic clip;
  always_comb begin
    rnd = ({{(RW-1){1'b0}}, 1'b1} << shift) >> 1;
    sh = (RW'(in_data) + rnd) >>> shift;
    clip = sh > HI || sh < LO;
    y = sh > HI ? HI[OW-1:0] : sh < LO ? LO[OW-1:0] : sh[OW-1:0];
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= y;
      sat_flag <= (in_valid && clip) || (sat_flag && !sat_clr);
    end
endmodule

// File: rtl/nf_channel_filter.sv
// nf_channel_filter: multi-channel FIR sum over double-banked coefficients with gain, rounding and saturation
module nf_channel_filter import crpa_pkg::*; #(
  parameter int NCH = NCH_D,
  parameter int NT = NT_D,
  parameter int WIDTH = WIDTH_D,
  parameter int CFWIDTH = CFWIDTH_D,
  parameter int NORM_WIDTH = NORM_WIDTH_D,
  parameter int OUT_WIDTH = OUT_WIDTH_D
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [NCH*WIDTH-1:0]         in_data,
  input  logic                         cf_wr_en,
  input  logic [clog2(NCH*NT)-1:0]     cf_wr_addr,
  input  logic [CFWIDTH-1:0]           cf_wr_data,
  input  logic                         cf_commit,
  output logic                         cf_busy,
  input  logic signed [NORM_WIDTH-1:0] norm,
  input  logic [4:0]                   shift,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         sat_flag,
  input  logic                         sat_clr
);
  localparam int N = NCH * NT;
  localparam int LG = clog2(N);
  localparam int P = 1 << LG;
  localparam int ACC_W = acc_w(WIDTH, CFWIDTH, N);
  localparam int MW = ACC_W + NORM_WIDTH;
  logic signed [WIDTH-1:0] dl [NCH][NT];
  logic signed [CFWIDTH-1:0] bk [2][N];
  logic signed [ACC_W-1:0] tr [LG+1][P];
  logic signed [MW-1:0] nm;
  logic [LG+2:0] v;
  logic sel, pend;
  assign cf_busy = pend;
  always_ff @(posedge clk)
    if (!resetn) begin
      dl <= '{default: '0};
      bk <= '{default: '0};
      sel <= 1'b0;
      pend <= 1'b0;
      v <= '0;
    end else begin
      v <= {v[LG+1:0], in_valid};
      if (in_valid)
        for (int c = 0; c < NCH; c++) begin
          dl[c][0] <= in_data[c*WIDTH +: WIDTH];
          for (int t = 1; t < NT; t++) dl[c][t] <= dl[c][t-1];
        end
      if (cf_wr_en && !pend && int'(cf_wr_addr) < N) bk[!sel][cf_wr_addr] <= cf_wr_data;
      // bank flips with the sample that lands this edge, so its products already see the new bank
      if (pend && in_valid) begin
        sel <= !sel;
        pend <= 1'b0;
      end else if (cf_commit) pend <= 1'b1;
    end
  // data path carries no reset: the valid tags alone decide what reaches the output
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < NT; t++)
        tr[0][c*NT+t] <= ACC_W'(dl[c][t]) * ACC_W'(bk[sel][c*NT+t]);
    for (int i = N; i < P; i++) tr[0][i] <= '0;
    for (int l = 0; l < LG; l++)
      for (int i = 0; i < P/2; i++) begin
        tr[l+1][i] <= tr[l][2*i] + tr[l][2*i+1];
        tr[l+1][i+P/2] <= '0;
      end
    nm <= MW'(norm) * MW'(tr[LG][0]);
  end
  nf_sat_round #(.IW(MW), .OW(OUT_WIDTH)) u_sat_round (
    .clk(clk),
    .resetn(resetn),
    .in_valid(v[LG+2]),
    .in_data(nm),
    .shift(shift),
    .sat_clr(sat_clr),
    .out_valid(out_valid),
    .out_data(out_data),
    .sat_flag(sat_flag)
  );
endmodule
